// File: rtl/seq_stream_checker.sv
// Receive-side checker for an incrementing-counter stream: locks on the first beat,
// then counts matches and mismatches against a modulo-2^DW increment until the stream goes idle.
module seq_stream_checker #(
    parameter int DW       = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_data,
    output logic             o_ready,
    input  logic             i_clear,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_err,
    output logic             o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_n;
    logic [DW-1:0]    expected, expected_n;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
    logic [CNT_W-1:0] match_cnt, match_cnt_n;
    logic [CNT_W-1:0] err_cnt, err_cnt_n;
    logic             err_n;
    logic             accept;

    assign o_ready     = (state != ST_DONE);
    assign o_locked    = (state == ST_LOCK);
    assign o_done      = (state == ST_DONE);
    assign o_match_cnt = match_cnt;
    assign o_err_cnt   = err_cnt;
    assign accept      = i_valid && o_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            expected  <= '0;
            idle_cnt  <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            o_err     <= 1'b0;
        end else begin
            state     <= state_n;
            expected  <= expected_n;
            idle_cnt  <= idle_cnt_n;
            match_cnt <= match_cnt_n;
            err_cnt   <= err_cnt_n;
            o_err     <= err_n;
        end
    end

    // NOTE: every signal gets a hold/default value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_n     = state;
        expected_n  = expected;
        idle_cnt_n  = idle_cnt;
        match_cnt_n = match_cnt;
        err_cnt_n   = err_cnt;
        err_n       = 1'b0;

        if (i_clear) begin
            // Clear wins over a beat in the same cycle; that beat is dropped.
            state_n     = ST_IDLE;
            idle_cnt_n  = '0;
            match_cnt_n = '0;
            err_cnt_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        expected_n = i_data + DW'(1);
                        state_n    = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (accept) begin
                        idle_cnt_n = '0;
                        if (i_data == expected) begin
                            expected_n = expected + DW'(1);
                            if (match_cnt != CNT_MAX) match_cnt_n = match_cnt + CNT_W'(1);
                        end else begin
                            expected_n = i_data + DW'(1);
                            err_n      = 1'b1;
                            if (err_cnt != CNT_MAX) err_cnt_n = err_cnt + CNT_W'(1);
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        idle_cnt_n = idle_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed bench for seq_stream_checker: a vector table for the main stream scenarios,
// plus hand-written sequences for saturation (narrow counters) and mid-stream reset.
module tb_seq_stream_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid, clear;
    logic [3:0] data;
    logic       ready, locked, err, done;
    logic [7:0] match_cnt, err_cnt;

    logic       v3, c3;
    logic [3:0] d3;
    logic       ready3, locked3, err3, done3;
    logic [2:0] match3, errc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_stream_checker #(.DW(4), .CNT_W(8), .HOLD_MAX(16)) dut (
        .clk(clk), .rst(rst), .i_valid(valid), .i_data(data), .o_ready(ready),
        .i_clear(clear), .o_locked(locked), .o_match_cnt(match_cnt),
        .o_err_cnt(err_cnt), .o_err(err), .o_done(done)
    );

    seq_stream_checker #(.DW(4), .CNT_W(3), .HOLD_MAX(7)) dut3 (
        .clk(clk), .rst(rst), .i_valid(v3), .i_data(d3), .o_ready(ready3),
        .i_clear(c3), .o_locked(locked3), .o_match_cnt(match3),
        .o_err_cnt(errc3), .o_err(err3), .o_done(done3)
    );

    typedef struct {
        logic       valid;
        logic [3:0] data;
        logic       clear;
        logic       locked;
        logic [7:0] mcnt;
        logic [7:0] ecnt;
        logic       err;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [3:0] d, input logic c,
                                input logic lk, input int m, input int e,
                                input logic er, input logic dn);
        vec_t t;
        t.valid = v;  t.data = d;  t.clear = c;
        t.locked = lk; t.mcnt = 8'(m); t.ecnt = 8'(e); t.err = er; t.done = dn;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp3;
        int         pulses;

        // Beats 1..10: first locks, the other nine match.
        add(1, 4'd1, 0, 1, 0, 0, 0, 0);
        for (int k = 2; k <= 10; k++) add(1, 4'(k), 0, 1, k - 1, 0, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, 4'd0, 0, 1, 9, 0, 0, 0);
        add(0, 4'd0, 0, 0, 9, 0, 0, 1);
        // DONE ignores beats; a clear with a beat in the same cycle drops that beat.
        add(1, 4'd5, 0, 0, 9, 0, 0, 1);
        add(1, 4'd6, 0, 0, 9, 0, 0, 1);
        add(1, 4'd3, 1, 0, 0, 0, 0, 0);
        // Relock on 14, then 15,0,1,2 across the wrap.
        add(1, 4'd14, 0, 1, 0, 0, 0, 0);
        add(1, 4'd15, 0, 1, 1, 0, 0, 0);
        add(1, 4'd0,  0, 1, 2, 0, 0, 0);
        add(0, 4'd9,  0, 1, 2, 0, 0, 0);
        add(1, 4'd1,  0, 1, 3, 0, 0, 0);
        add(1, 4'd2,  0, 1, 4, 0, 0, 0);
        add(0, 4'd0,  1, 0, 0, 0, 0, 0);
        // 3,4,9,10,11: one mismatch at 9 with a single-cycle err pulse.
        add(1, 4'd3,  0, 1, 0, 0, 0, 0);
        add(1, 4'd4,  0, 1, 1, 0, 0, 0);
        add(1, 4'd9,  0, 1, 1, 1, 1, 0);
        add(1, 4'd10, 0, 1, 2, 1, 0, 0);
        add(1, 4'd11, 0, 1, 3, 1, 0, 0);
        // 15 idles then a beat restarts the idle count; done only after 16 straight idles.
        for (int k = 1; k <= 15; k++) add(0, 4'd0, 0, 1, 3, 1, 0, 0);
        add(1, 4'd12, 0, 1, 4, 1, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, 4'd0, 0, 1, 4, 1, 0, 0);
        add(0, 4'd0, 0, 0, 4, 1, 0, 1);

        rst = 1'b0; valid = 0; data = '0; clear = 0;
        v3 = 0; d3 = '0; c3 = 0;
        #12;
        check("reset ready", ready, 1);
        check("reset locked", locked, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset match_cnt", match_cnt, 0);
        check("reset err_cnt", err_cnt, 0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            valid = vecs[i].valid;
            data  = vecs[i].data;
            clear = vecs[i].clear;
            step();
            check($sformatf("v%0d locked", i), locked, vecs[i].locked);
            check($sformatf("v%0d match_cnt", i), match_cnt, vecs[i].mcnt);
            check($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].ecnt);
            check($sformatf("v%0d err", i), err, vecs[i].err);
            check($sformatf("v%0d done", i), done, vecs[i].done);
            check($sformatf("v%0d ready", i), ready, !vecs[i].done);
        end
        valid = 0; clear = 0;

        // Narrow counters: 12 matches saturate at 7; 9 mismatches saturate err_cnt but all pulse.
        v3 = 1; d3 = 4'd0;
        step();
        check("sat lock", locked3, 1);
        for (int k = 1; k <= 12; k++) begin
            d3 = 4'(k);
            step();
            check($sformatf("sat match k%0d", k), match3, (k < 7) ? k : 7);
        end
        exp3 = 4'd13;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            v3 = 1;
            d3 = exp3 + 4'd3;
            exp3 = d3 + 4'd1;
            step();
            if (err3) pulses++;
            check($sformatf("sat err pulse %0d", i), err3, 1);
            check($sformatf("sat err_cnt %0d", i), errc3, (i < 7) ? i : 7);
            check($sformatf("sat match held %0d", i), match3, 7);
            v3 = 0;
            step();
            check($sformatf("sat err gap %0d", i), err3, 0);
        end
        check("sat pulse count", pulses, 9);

        // Reset mid-stream: outputs drop immediately, next beat relocks without counting.
        clear = 1;
        step();
        clear = 0;
        for (int k = 0; k <= 5; k++) begin
            valid = 1; data = 4'(k);
            step();
        end
        valid = 0;
        check("pre-reset match_cnt", match_cnt, 5);
        check("pre-reset locked", locked, 1);
        rst = 1'b0;
        #1;
        check("async rst locked", locked, 0);
        check("async rst match_cnt", match_cnt, 0);
        check("async rst err_cnt", err_cnt, 0);
        check("async rst ready", ready, 1);
        check("async rst done", done, 0);
        rst = 1'b1;
        #1;
        valid = 1; data = 4'd7;
        step();
        check("relock locked", locked, 1);
        check("relock match_cnt", match_cnt, 0);
        data = 4'd8;
        step();
        check("relock match 8", match_cnt, 1);
        check("relock err_cnt", err_cnt, 0);
        valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_stream_checker.md
Name: seq_stream_checker

Overview:
- Receive-side checker for the incrementing-counter stimulus stream driven by the unit-level benches.
- Accepts a DW-bit data stream over a valid/ready handshake and locks onto the first accepted value.
- Checks every following beat against a modulo-2^DW increment and keeps saturating match and error counts.
- Raises done once the stream has been idle for HOLD_MAX cycles, so the Nicotb Python side can sample final counters.

Parameters:
DW, 4, data width; the expected-value arithmetic is modulo 2^DW
CNT_W, 8, width of the match and error counters; both saturate at 2^CNT_W-1
HOLD_MAX, 16, consecutive idle cycles in LOCK before done asserts; legal range 1..2^CNT_W-1

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  asynchronous active-low reset
i_valid  input  1  beat present
i_data  input  DW  beat payload
o_ready  output  1  checker can accept a beat
i_clear  input  1  synchronous clear; returns the block to IDLE and zeroes the counters
o_locked  output  1  high in LOCK state
o_match_cnt  output  CNT_W  beats that matched the expected value
o_err_cnt  output  CNT_W  beats that mismatched
o_err  output  1  one-cycle pulse, registered, in the cycle after a mismatching beat is accepted
o_done  output  1  high in DONE state

Behaviour:
- Handshake: a beat is accepted when i_valid && o_ready at the rising edge.
  - o_ready is combinational from the state: 1 in IDLE and LOCK, 0 in DONE.
  - i_valid may drop at any time; no stall or back-pressure is imposed beyond DONE.
- Reset (rst=0, async): state=IDLE, expected=0, idle_cnt=0, counters=0, o_err=0, o_locked=0, o_done=0, o_ready=1.
- State machine (IDLE, LOCK, DONE), registered:
  - IDLE: first accepted beat sets expected=i_data+1 (mod 2^DW) and moves to LOCK. Counters are unchanged and no check is made.
  - LOCK, accepted beat equal to expected: match_cnt+1 (saturating), expected+1 (wraps 2^DW-1 -> 0), idle_cnt=0.
  - LOCK, accepted beat not equal to expected: err_cnt+1 (saturating), o_err=1 next cycle, expected resyncs to i_data+1, idle_cnt=0, state stays LOCK.
  - LOCK, no accepted beat: idle_cnt+1. When idle_cnt reaches HOLD_MAX-1 and this cycle is also idle, move to DONE. Done is therefore high after exactly HOLD_MAX consecutive idle cycles.
  - DONE: o_ready=0, counters and expected are held, beats are ignored. Only i_clear or reset leaves DONE.
- i_clear (sync, any state): next state=IDLE, counters=0, idle_cnt=0, o_err=0.
  - It has priority over a beat accepted in the same cycle; that beat is dropped and not counted.
- Saturation: at 2^CNT_W-1 a counter holds. o_err still pulses on every mismatch.
- Wrap: the compare is DW-bit modulo. The sequence ...,2^DW-1,0 is a match.
- IDLE is never left by a timeout; idle_cnt counts only in LOCK.
- Reset asserted mid-stream aborts immediately to the reset values. The first beat after release re-locks without counting.
- Outputs o_locked, o_done and the counters are registered, zero-latency state views. No combinational path from i_data to any output.

Test Plan:
1. Reset release, then beats 1..10 on consecutive cycles, then valid low -> o_locked=1 after beat 1, o_match_cnt=9, o_err_cnt=0; o_done rises exactly 16 cycles after the last beat and o_ready=0.
2. Beats 14,15,0,1,2 (DW=4 wrap) -> o_match_cnt=4, o_err_cnt=0.
3. Beats 3,4,9,10,11 -> one o_err pulse, in the cycle after 9 is accepted; o_err_cnt=1, o_match_cnt=3 (4, 10, 11).
4. In DONE, drive beats then i_clear together with a valid beat -> no count change while in DONE; the clear-cycle beat is not counted; state=IDLE, counters=0, o_ready=1; the next beat re-locks.
5. CNT_W=3, 12 matching beats -> o_match_cnt saturates at 7. Then 9 alternating mismatches -> o_err_cnt=7 with 9 o_err pulses.
6. rst pulsed low for 1 ns during LOCK with match_cnt=5 -> all outputs at reset values immediately (before the next clk edge); the next beat 7 re-locks, and beat 8 gives o_match_cnt=1.
